// File: rtl/cla_pipe.sv
// Two-stage pipelined carry-lookahead adder/subtractor with valid/ready handshakes.
// Stage 1 registers operands and group generate/propagate; stage 2 resolves carries and sums.
module cla_pipe #(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned GROUP = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    input  logic             sub,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             overflow
);

    localparam int unsigned NGRP = WIDTH / GROUP;

    // Stage 1 state
    logic             s1_valid_q;
    logic [WIDTH-1:0] s1_a_q;
    logic [WIDTH-1:0] s1_b_q;
    logic             s1_c0_q;
    logic [NGRP-1:0]  s1_gg_q;
    logic [NGRP-1:0]  s1_gp_q;

    // Stage 2 (output) state
    logic             out_valid_q;
    logic [WIDTH-1:0] sum_q;
    logic             cout_q;
    logic             ovf_q;

    logic             adv2;
    logic             accept;
    logic             s1_adv;

    logic [WIDTH-1:0] b_eff;
    logic             c0;
    logic [WIDTH-1:0] g_in;
    logic [WIDTH-1:0] p_in;
    logic [NGRP-1:0]  gg_d;
    logic [NGRP-1:0]  gp_d;
    logic             g_acc;
    logic             p_acc;

    logic [WIDTH-1:0] g_s1;
    logic [WIDTH-1:0] p_s1;
    logic [NGRP-1:0]  grp_cin;
    logic [WIDTH-1:0] carry;
    logic             gc_run;
    logic             cc_run;
    logic             c_msb_in;
    logic             c_out;
    logic [WIDTH-1:0] sum_d;

    // Handshake control
    always_comb begin
        adv2     = !out_valid_q || out_ready;
        in_ready = rst_n && (!s1_valid_q || adv2);
        accept   = in_valid && in_ready;
        s1_adv   = s1_valid_q && adv2;
    end

    // Stage 1: effective operands and per-group G/P, rippled within each group
    always_comb begin
        b_eff = sub ? ~b : b;
        c0    = cin ^ sub;
        g_in  = a & b_eff;
        p_in  = a | b_eff;
        gg_d  = '0;
        gp_d  = '0;
        g_acc = 1'b0;
        p_acc = 1'b1;
        for (int unsigned i = 0; i < NGRP; i++) begin
            g_acc = 1'b0;
            p_acc = 1'b1;
            for (int unsigned j = 0; j < GROUP; j++) begin
                g_acc = g_in[i*GROUP+j] | (p_in[i*GROUP+j] & g_acc);
                p_acc = p_in[i*GROUP+j] & p_acc;
            end
            gg_d[i] = g_acc;
            gp_d[i] = p_acc;
        end
    end

    // Stage 2: group carry-ins from the registered group terms, then intra-group carries
    always_comb begin
        g_s1    = s1_a_q & s1_b_q;
        p_s1    = s1_a_q | s1_b_q;
        grp_cin = '0;
        gc_run  = s1_c0_q;
        for (int unsigned i = 0; i < NGRP; i++) begin
            grp_cin[i] = gc_run;
            gc_run     = s1_gg_q[i] | (s1_gp_q[i] & gc_run);
        end
        c_out    = gc_run;

        carry    = '0;
        cc_run   = 1'b0;
        c_msb_in = 1'b0;
        for (int unsigned i = 0; i < NGRP; i++) begin
            cc_run = grp_cin[i];
            for (int unsigned j = 0; j < GROUP; j++) begin
                carry[i*GROUP+j] = cc_run;
                cc_run = g_s1[i*GROUP+j] | (p_s1[i*GROUP+j] & cc_run);
            end
        end
        c_msb_in = carry[WIDTH-1];
        sum_d    = s1_a_q ^ s1_b_q ^ carry;
    end

    // Control and output registers, cleared by reset
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            s1_valid_q  <= 1'b0;
            out_valid_q <= 1'b0;
            sum_q       <= '0;
            cout_q      <= 1'b0;
            ovf_q       <= 1'b0;
        end else begin
            if (accept) begin
                s1_valid_q <= 1'b1;
            end else if (s1_adv) begin
                s1_valid_q <= 1'b0;
            end

            if (s1_adv) begin
                out_valid_q <= 1'b1;
                sum_q       <= sum_d;
                cout_q      <= c_out;
                ovf_q       <= c_msb_in ^ c_out;
            end else if (out_ready) begin
                out_valid_q <= 1'b0;
            end
        end
    end

    // Stage 1 datapath needs no reset; it is only consumed while s1_valid_q is set
    always_ff @(posedge clk) begin
        if (accept) begin
            s1_a_q  <= a;
            s1_b_q  <= b_eff;
            s1_c0_q <= c0;
            s1_gg_q <= gg_d;
            s1_gp_q <= gp_d;
        end
    end

    assign out_valid = out_valid_q;
    assign sum       = sum_q;
    assign cout      = cout_q;
    assign overflow  = ovf_q;

endmodule
